// File: rtl/vend_pkg.sv
// Shared vending definitions: entry-stage states, coin codes and the FSM price states.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    ISSUE   = 2'b10,
    HOLD    = 2'b11
  } entry_state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;

  // Price states tracked by the downstream vending FSM.
  localparam logic [1:0] PRICE_ZERO    = 2'b00;
  localparam logic [1:0] PRICE_QUARTER = 2'b01;
  localparam logic [1:0] PRICE_HALF    = 2'b10;

endpackage

// File: rtl/coin_entry_ctrl_if.sv
// Request/status bundle between the coin entry stage and the vending FSM.
interface coin_entry_ctrl_if;
  logic [1:0] Coin_insert;
  logic       C_A;
  logic       S_A;
  logic       BTN_sensor;
  logic       refund_pulse;
  logic       reject_pulse;
  logic       vend_busy;

  modport master (
    output Coin_insert, C_A, S_A, BTN_sensor, refund_pulse, reject_pulse,
    input  vend_busy
  );

  modport slave (
    input  Coin_insert, C_A, S_A, BTN_sensor, refund_pulse, reject_pulse,
    output vend_busy
  );
endinterface

// File: rtl/btn_debounce.sv
// Button front end: 2-FF synchroniser, debounce counter, debounced rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 2
) (
  input  logic slow_CLK,
  input  logic RST,
  input  logic btn,
  output logic evt
);
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1, sync2, level, level_d;
  logic [CW-1:0] cnt;

  // Level flips on the sample after DEB_CYCLES differing samples, so a pulse of
  // DEB_CYCLES samples or fewer never reaches the level.
  always_ff @(posedge slow_CLK or posedge RST) begin
    if (RST) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 != level) begin
        if (cnt == CW'(DEB_CYCLES)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign evt = level & ~level_d;
endmodule

// File: rtl/coin_entry_ctrl.sv
// Coin entry stage: debounced buttons feed credit/selection accumulation and
// the request / refund / reject pulses for the vending FSM.
module coin_entry_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 100,
  parameter int unsigned HOLDOFF    = 7
) (
  input  logic slow_CLK,
  input  logic RST,
  input  logic coin_btn,
  input  logic cand_btn,
  input  logic soda_btn,
  input  logic conf_btn,
  input  logic canc_btn,
  coin_entry_ctrl_if.master bus
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned HW = $clog2(HOLDOFF + 1);

  logic coin_ev, cand_ev, soda_ev, conf_ev, canc_ev;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_coin (.slow_CLK(slow_CLK), .RST(RST), .btn(coin_btn), .evt(coin_ev));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_cand (.slow_CLK(slow_CLK), .RST(RST), .btn(cand_btn), .evt(cand_ev));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_soda (.slow_CLK(slow_CLK), .RST(RST), .btn(soda_btn), .evt(soda_ev));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_conf (.slow_CLK(slow_CLK), .RST(RST), .btn(conf_btn), .evt(conf_ev));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_canc (.slow_CLK(slow_CLK), .RST(RST), .btn(canc_btn), .evt(canc_ev));

  entry_state_t  state, state_n;
  logic [1:0]    credit, credit_n;
  logic          ca, ca_n, sa, sa_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          btn_q, btn_n, ref_q, ref_n, rej_q, rej_n;

  logic [1:0]    acc_credit;
  logic          acc_rej, acc_ca, acc_sa, acc_any, acc_nonempty, abort;

  always_ff @(posedge slow_CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      credit <= COIN_NONE;
      ca     <= 1'b0;
      sa     <= 1'b0;
      tcnt   <= '0;
      hcnt   <= '0;
      btn_q  <= 1'b0;
      ref_q  <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      state  <= state_n;
      credit <= credit_n;
      ca     <= ca_n;
      sa     <= sa_n;
      tcnt   <= tcnt_n;
      hcnt   <= hcnt_n;
      btn_q  <= btn_n;
      ref_q  <= ref_n;
      rej_q  <= rej_n;
    end
  end

  always_comb begin
    // Coin/selection result if this cycle's entry events were accepted.
    acc_credit = credit;
    acc_rej    = 1'b0;
    acc_ca     = ca;
    acc_sa     = sa;
    if (coin_ev) begin
      if (credit == COIN_TWO) acc_rej = 1'b1;
      else                    acc_credit = credit + 2'd1;
    end
    if (cand_ev && !soda_ev) begin
      acc_ca = 1'b1;
      acc_sa = 1'b0;
    end else if (soda_ev && !cand_ev) begin
      acc_sa = 1'b1;
      acc_ca = 1'b0;
    end
    acc_any      = coin_ev | cand_ev | soda_ev;
    acc_nonempty = (acc_credit != COIN_NONE) || acc_ca || acc_sa;

    state_n  = state;
    credit_n = credit;
    ca_n     = ca;
    sa_n     = sa;
    tcnt_n   = tcnt;
    hcnt_n   = hcnt;
    btn_n    = 1'b0;
    ref_n    = 1'b0;
    rej_n    = 1'b0;
    abort    = 1'b0;

    case (state)
      IDLE, COLLECT: begin
        if (canc_ev) begin
          abort = (state == COLLECT);
        end else if (conf_ev && !bus.vend_busy) begin
          state_n = ISSUE;
          btn_n   = 1'b1;
        end else if (acc_any) begin
          credit_n = acc_credit;
          ca_n     = acc_ca;
          sa_n     = acc_sa;
          rej_n    = acc_rej;
          tcnt_n   = '0;
          state_n  = acc_nonempty ? COLLECT : state;
        end else if (state == COLLECT) begin
          if (tcnt == TW'(TIMEOUT - 1)) abort = 1'b1;
          else                          tcnt_n = tcnt + TW'(1);
        end
      end
      ISSUE: begin
        credit_n = COIN_NONE;
        ca_n     = 1'b0;
        sa_n     = 1'b0;
        hcnt_n   = HW'(HOLDOFF - 1);
        state_n  = HOLD;
      end
      HOLD: begin
        credit_n = acc_credit;
        ca_n     = acc_ca;
        sa_n     = acc_sa;
        rej_n    = acc_rej;
        if (hcnt == '0) begin
          state_n = acc_nonempty ? COLLECT : IDLE;
          tcnt_n  = '0;
        end else begin
          hcnt_n = hcnt - HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Cancel and timeout share one exit path.
    if (abort) begin
      ref_n    = (credit != COIN_NONE);
      credit_n = COIN_NONE;
      ca_n     = 1'b0;
      sa_n     = 1'b0;
      tcnt_n   = '0;
      state_n  = IDLE;
    end
  end

  assign bus.Coin_insert  = credit;
  assign bus.C_A          = ca;
  assign bus.S_A          = sa;
  assign bus.BTN_sensor   = btn_q;
  assign bus.refund_pulse = ref_q;
  assign bus.reject_pulse = rej_q;
endmodule

// File: tb/tb_coin_entry_ctrl.sv
// Scoreboard bench for coin_entry_ctrl: expected pulses queued with stimulus, popped by a monitor.
module tb_coin_entry_ctrl;
  localparam int unsigned TIMEOUT = 100;

  logic       slow_CLK = 1'b0;
  logic       RST;
  logic [4:0] btns;   // {canc, conf, soda, cand, coin}

  coin_entry_ctrl_if bus ();

  coin_entry_ctrl #(.DEB_CYCLES(2), .TIMEOUT(TIMEOUT), .HOLDOFF(7)) dut (
    .slow_CLK (slow_CLK),
    .RST      (RST),
    .coin_btn (btns[0]),
    .cand_btn (btns[1]),
    .soda_btn (btns[2]),
    .conf_btn (btns[3]),
    .canc_btn (btns[4]),
    .bus      (bus.master)
  );

  always #5 slow_CLK = ~slow_CLK;

  localparam logic [4:0] B_COIN = 5'b00001, B_CAND = 5'b00010, B_SODA = 5'b00100,
                         B_CONF = 5'b01000, B_CANC = 5'b10000;

  logic [6:0] obs;
  assign obs = {bus.BTN_sensor, bus.refund_pulse, bus.reject_pulse, bus.Coin_insert, bus.C_A, bus.S_A};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [6:0]  exp_q[$];
  logic [6:0]  mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] mkv(input logic b, input logic r, input logic j,
                                     input logic [1:0] c, input logic a, input logic s);
    return {b, r, j, c, a, s};
  endfunction

  always @(negedge slow_CLK) begin
    if (!RST && (bus.BTN_sensor || bus.refund_pulse || bus.reject_pulse)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(obs), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pulse", 32'(obs), 32'(mon_exp));
      end
    end
  end

  task automatic press(input logic [4:0] mask);
    @(negedge slow_CLK) btns = mask;
    repeat (5) @(negedge slow_CLK);
    btns = '0;
    repeat (8) @(negedge slow_CLK);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge slow_CLK);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!bus.BTN_sensor && n < 40) begin
      @(negedge slow_CLK);
      n++;
    end
    check("issue_seen", 32'(bus.BTN_sensor), 32'd1);
  endtask

  initial begin
    int cnt;
    btns = '0;
    bus.vend_busy = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge slow_CLK);
    check("reset", 32'(obs), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge slow_CLK);

    // 1 coin, candy, confirm
    exp_q.push_back(mkv(1, 0, 0, 2'b01, 1, 0));
    press(B_COIN);
    press(B_CAND);
    check("collect_1c_candy", 32'(obs), 32'(mkv(0, 0, 0, 2'b01, 1, 0)));
    press(B_CONF);
    wait_drain("drain_issue1");
    repeat (12) @(negedge slow_CLK);
    check("after_issue1", 32'(obs), 32'd0);

    // 3 coins (third rejected), soda, confirm
    exp_q.push_back(mkv(0, 0, 1, 2'b10, 0, 0));
    exp_q.push_back(mkv(1, 0, 0, 2'b10, 0, 1));
    press(B_COIN);
    press(B_COIN);
    press(B_COIN);
    press(B_SODA);
    press(B_CONF);
    wait_drain("drain_issue2");
    repeat (12) @(negedge slow_CLK);

    // one-cycle glitch filtered; bouncing press counts once
    @(negedge slow_CLK) btns = B_COIN;
    @(negedge slow_CLK) btns = '0;
    repeat (10) @(negedge slow_CLK);
    check("glitch", 32'(obs), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge slow_CLK) btns = (i % 2 == 0) ? B_COIN : 5'b0;
    end
    @(negedge slow_CLK) btns = B_COIN;
    repeat (6) @(negedge slow_CLK);
    btns = '0;
    repeat (10) @(negedge slow_CLK);
    check("bounce_count", 32'(obs), 32'(mkv(0, 0, 0, 2'b01, 0, 0)));
    exp_q.push_back(mkv(1, 0, 0, 2'b01, 0, 0));
    press(B_CONF);
    wait_drain("drain_issue3");
    repeat (12) @(negedge slow_CLK);

    // 2 coins then timeout refund after TIMEOUT idle cycles
    exp_q.push_back(mkv(0, 1, 0, 2'b00, 0, 0));
    press(B_COIN);
    @(negedge slow_CLK) btns = B_COIN;
    cnt = 0;
    while (bus.Coin_insert != 2'b10 && cnt < 20) begin
      @(negedge slow_CLK);
      cnt++;
    end
    check("second_coin", 32'(bus.Coin_insert), 32'd2);
    btns = '0;
    cnt = 0;
    do begin
      @(negedge slow_CLK);
      cnt++;
    end while (!bus.refund_pulse && cnt < 200);
    check("timeout_cycles", 32'(cnt), 32'(TIMEOUT));
    @(negedge slow_CLK);
    check("after_timeout", 32'(obs), 32'd0);
    wait_drain("drain_timeout");

    // cancel with selection only: no refund
    press(B_CAND);
    press(B_CANC);
    check("cancel_empty", 32'(obs), 32'd0);

    // confirm while busy is dropped
    press(B_COIN);
    press(B_CAND);
    bus.vend_busy = 1'b1;
    press(B_CONF);
    bus.vend_busy = 1'b0;
    check("busy_drop", 32'(obs), 32'(mkv(0, 0, 0, 2'b01, 1, 0)));

    // issue, then confirm + coin landing inside HOLD
    exp_q.push_back(mkv(1, 0, 0, 2'b01, 1, 0));
    @(negedge slow_CLK) btns = B_CONF;
    repeat (3) @(negedge slow_CLK);
    btns = '0;
    repeat (3) @(negedge slow_CLK);
    btns = B_CONF | B_COIN;
    repeat (5) @(negedge slow_CLK);
    btns = '0;
    repeat (20) @(negedge slow_CLK);
    wait_drain("drain_issue4");
    check("hold_coin", 32'(obs), 32'(mkv(0, 0, 0, 2'b01, 0, 0)));
    exp_q.push_back(mkv(0, 1, 0, 2'b00, 0, 0));
    press(B_CANC);
    wait_drain("drain_cancel");
    check("after_cancel", 32'(obs), 32'd0);

    // same-cycle cancel + confirm with one coin: refund only
    press(B_COIN);
    exp_q.push_back(mkv(0, 1, 0, 2'b00, 0, 0));
    press(B_CANC | B_CONF);
    wait_drain("drain_canc_conf");
    repeat (12) @(negedge slow_CLK);
    check("after_canc_conf", 32'(obs), 32'd0);

    // reset asserted during ISSUE
    press(B_COIN);
    exp_q.push_back(mkv(1, 0, 0, 2'b01, 0, 0));
    @(negedge slow_CLK) btns = B_CONF;
    wait_issue();
    #1 RST = 1'b1;
    #1 check("rst_async", 32'(obs), 32'd0);
    btns = '0;
    repeat (3) @(negedge slow_CLK);
    RST = 1'b0;
    repeat (20) @(negedge slow_CLK);
    check("after_rst", 32'(obs), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/coin_entry_ctrl.md
# coin_entry_ctrl

Front-panel input stage directly upstream of the vending FSM. It takes the raw push-buttons (coin slot, candy, soda, confirm, cancel), synchronises and debounces them, and accumulates the coin credit and product selection. On confirm it issues one registered request pulse (`BTN_sensor`) with stable `Coin_insert`/`C_A`/`S_A`. It also provides cancel/timeout refund and lockout while a vend is in progress.

## Interface
- `DEB_CYCLES`, default 2: consecutive stable samples required to change a debounced level.
- `TIMEOUT`, default 100: idle cycles in COLLECT before auto-refund (10 s at 10 Hz).
- `HOLDOFF`, default 7: cycles after an issue during which confirm is ignored. Covers the FSM's 6-cycle dispense/error dwell plus its return to idle.
- `slow_CLK`  in  1  10 Hz system clock; all state updates on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `coin_btn`, `cand_btn`, `soda_btn`, `conf_btn`, `canc_btn`  in  1 each  raw asynchronous buttons, active-high.
- `vend_busy`  in  1  top level ties this to `C_D | S_D`; while high, confirm is ignored.
- `Coin_insert`  out  2  credit code: 00 none, 01 one coin ($0.25), 10 two coins ($0.50). 11 is never driven.
- `C_A`, `S_A`  out  1 each  candy / soda selection, mutually exclusive.
- `BTN_sensor`  out  1  one-cycle request pulse to the FSM.
- `refund_pulse`  out  1  one-cycle pulse: all inserted credit returned.
- `reject_pulse`  out  1  one-cycle pulse: coin refused because credit is already at 2.

## Operation
- Every output resets to 0. State resets to IDLE; all counters and debounced levels reset to 0.
- Per button:
  - 2-FF synchroniser.
  - Debouncer: the level flips after DEB_CYCLES consecutive synced samples differ from it.
  - Event: one-cycle pulse on the debounced rising edge.
- States:
  - IDLE: credit = 0 and no selection.
  - COLLECT: credit or selection is non-zero.
  - ISSUE: exactly one cycle.
  - HOLD: HOLDOFF-cycle countdown.
- Same-cycle event priority: cancel > confirm > coin/selection.
- Coin event:
  - credit < 2: credit increments.
  - credit = 2: `reject_pulse`, credit unchanged (saturating).
- Candy event sets C_A=1, S_A=0. Soda event sets S_A=1, C_A=0. Simultaneous candy+soda events leave the selection unchanged.
- IDLE → COLLECT on any accepted coin or selection event.
- Confirm event in IDLE/COLLECT with `vend_busy`=0 → ISSUE.
  - Issued even with nothing entered; the FSM handles empty or error cases.
  - Confirm in IDLE/COLLECT with `vend_busy`=1 is dropped, not queued.
- ISSUE:
  - `BTN_sensor`=1 with `Coin_insert`/`C_A`/`S_A` holding the accumulated values.
  - Next cycle: credit and selection clear to 0, state → HOLD.
- HOLD:
  - Coin and selection events accumulate as in COLLECT; confirm and cancel events are ignored.
  - On expiry: → COLLECT if anything was accumulated, else → IDLE.
- Cancel event in COLLECT:
  - credit > 0: `refund_pulse`.
  - In all cases: credit and selection clear, state → IDLE.
  - Cancel in IDLE: no effect, no pulse.
- Timeout:
  - The counter runs only in COLLECT and resets on any accepted event.
  - On reaching TIMEOUT−1: behaves exactly as a cancel.
- RST mid-operation (including during ISSUE): `BTN_sensor` drops immediately, credit is lost, no refund pulse.

## Timing
- All outputs are registered.
- Latency: a button held stable from before edge 0 produces its event-driven register update at edge 3+DEB_CYCLES (edge 5 at default).
- `BTN_sensor` is high for exactly one slow_CLK cycle. The FSM samples it at the following edge.
- `Coin_insert`/`C_A`/`S_A` are stable through the cycle before and the cycle of the `BTN_sensor` pulse.
- Pulses shorter than DEB_CYCLES+1 samples are filtered. A held button produces one event only.
- Minimum spacing between two `BTN_sensor` pulses: HOLDOFF+1 cycles.

## Structure
- Shared package `vend_pkg`:
  - state encodings IDLE/COLLECT/ISSUE/HOLD;
  - coin codes COIN_NONE=2'b00, COIN_ONE=2'b01, COIN_TWO=2'b10;
  - the FSM price-state constants, shared with the FSM.
- Sub-module `btn_debounce` (synchroniser + debounce counter + rising-edge pulse), parameterised by DEB_CYCLES, instantiated five times.
- Top level contains the credit counter, selection register, timeout/holdoff counters and the control FSM.

## Test plan
- 1 coin, candy, confirm → `BTN_sensor` one cycle with `Coin_insert`=01, C_A=1, S_A=0. The next cycle all are 0.
- 3 coin presses, soda, confirm → `reject_pulse` on the third coin. Request carries `Coin_insert`=10, S_A=1.
- Glitchy inputs:
  - a 1-cycle glitch on `coin_btn` → no event;
  - button bouncing 0/1 for 4 cycles, then stable → exactly one coin counted.
- 2 coins, then wait TIMEOUT cycles → `refund_pulse` one cycle, outputs 0, state IDLE. Cancel with 0 coins and a selection → no pulse.
- Confirm during HOLD and with `vend_busy`=1 → no `BTN_sensor`. A coin inserted in HOLD appears as `Coin_insert`=01 after HOLD.
- Same-cycle cancel+confirm with 1 coin → refund only. Assert RST during ISSUE → all outputs 0 asynchronously.
